// File: rtl/scs8hd_bist_pkg.sv
// Shared definitions for the a21o cell BIST: FSM states, vector space size,
// error counter width and the golden a21o response.
package scs8hd_bist_pkg;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned ERR_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } bist_state_t;

    // Vector index bits map to {A1, A2, B1}.
    function automatic logic a21o_expect(input logic [IDX_W-1:0] idx);
        return (idx[2] & idx[1]) | idx[0];
    endfunction

endpackage

// File: rtl/scs8hd_bist_vecgen.sv
// Vector sequencer: settle, vector-index and pass counters, plus the
// sample strobe (window closes) and last strobe (final vector of final pass).
module scs8hd_bist_vecgen
    import scs8hd_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_run,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_sample,
    output logic             o_last
);

    localparam logic [3:0]       SETTLE_MAX = 4'(SETTLE_CYCLES);
    localparam logic [7:0]       LOOP_MAX   = 8'(LOOPS - 1);
    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NUM_VEC - 1);

    logic [3:0]       r_settle;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_loop;

    assign o_idx    = r_idx;
    assign o_sample = i_run && (r_settle == SETTLE_MAX);
    assign o_last   = o_sample && (r_idx == IDX_MAX) && (r_loop == LOOP_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_settle <= '0;
            r_idx    <= '0;
            r_loop   <= '0;
        end else if (i_clear) begin
            r_settle <= '0;
            r_idx    <= '0;
            r_loop   <= '0;
        end else if (o_sample) begin
            // Index wraps 7->0 through natural 3-bit overflow.
            r_settle <= '0;
            r_idx    <= r_idx + 1'b1;
            if (r_idx == IDX_MAX) begin
                r_loop <= r_loop + 1'b1;
            end
        end else if (i_run) begin
            r_settle <= r_settle + 1'b1;
        end
    end

endmodule

// File: rtl/scs8hd_a21o_bist.sv
// BIST controller for an a21o cell: drives all 8 input vectors LOOPS times,
// compares the cell output against the golden response and reports results.
module scs8hd_a21o_bist
    import scs8hd_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic               CLK,
    input  logic               RESET_B,
    input  logic               START,
    input  logic               X_IN,
    output logic               A1,
    output logic               A2,
    output logic               B1,
    output logic               BUSY,
    output logic               DONE,
    output logic               PASS,
    output logic [ERR_W-1:0]   ERR_CNT,
    output logic [NUM_VEC-1:0] FAIL_VEC
`ifdef SC_USE_PG_PIN
    ,
    input  logic               vpwr,
    input  logic               vgnd,
    input  logic               vpb,
    input  logic               vnb
`endif
);

    bist_state_t        r_state;
    logic [IDX_W-1:0]   r_stim;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err;
    logic [NUM_VEC-1:0] r_fail;

    logic               w_accept;
    logic               w_run;
    logic [IDX_W-1:0]   w_idx;
    logic               w_sample;
    logic               w_last;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_next;

    assign w_accept = (r_state == ST_IDLE) && START;
    assign w_run    = (r_state == ST_RUN);

    scs8hd_bist_vecgen #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .LOOPS         (LOOPS)
    ) u_vecgen (
        .i_clk    (CLK),
        .i_rst_n  (RESET_B),
        .i_clear  (w_accept),
        .i_run    (w_run),
        .o_idx    (w_idx),
        .o_sample (w_sample),
        .o_last   (w_last)
    );

    assign w_mismatch = w_sample && (X_IN != a21o_expect(w_idx));
    assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state <= ST_IDLE;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_stim <= '0;
                    if (START) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_fail  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_sample) begin
                        r_err <= w_err_next;
                        if (w_mismatch) begin
                            r_fail[w_idx] <= 1'b1;
                        end
                        // PASS must reflect the final sample, so use the next count.
                        if (w_last) begin
                            r_state <= ST_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                            r_stim  <= '0;
                        end else begin
                            r_stim <= w_idx + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_stim  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_stim  <= '0;
                end
            endcase
        end
    end

    assign A1       = r_stim[2];
    assign A2       = r_stim[1];
    assign B1       = r_stim[0];
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign PASS     = r_pass;
    assign ERR_CNT  = r_err;
    assign FAIL_VEC = r_fail;

endmodule

// File: tb/tb_scs8hd_a21o_bist.sv
// Self-checking bench: three BIST instances with different SETTLE/LOOPS,
// each driving a modelled a21o cell with a per-vector fault mask.
module tb_scs8hd_a21o_bist;

    logic       clk;
    logic [2:0] rst_n;
    logic [2:0] start;
    logic [2:0] x_in;
    logic [2:0] a1, a2, b1, busy, done, pass;
    logic [3:0] err [3];
    logic [7:0] fv  [3];
    logic [7:0] xmask [3];

    int n_assert = 0;
    int n_fail   = 0;

    int s_of    [3] = '{2, 2, 0};
    int loops_of[3] = '{1, 3, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden a21o: X = (A1 AND A2) OR B1, from the index value i = 4*A1 + 2*A2 + B1.
    function automatic logic gold(input int i);
        return (((i / 4) * ((i / 2) % 2)) + (i % 2)) != 0;
    endfunction

    function automatic logic cell_out(input logic a, input logic b, input logic c,
                                      input logic [7:0] m);
        int i;
        i = int'(a) * 4 + int'(b) * 2 + int'(c);
        return gold(i) ^ m[i];
    endfunction

    assign x_in[0] = cell_out(a1[0], a2[0], b1[0], xmask[0]);
    assign x_in[1] = cell_out(a1[1], a2[1], b1[1], xmask[1]);
    assign x_in[2] = cell_out(a1[2], a2[2], b1[2], xmask[2]);

    scs8hd_a21o_bist u_dut0 (
        .CLK(clk), .RESET_B(rst_n[0]), .START(start[0]), .X_IN(x_in[0]),
        .A1(a1[0]), .A2(a2[0]), .B1(b1[0]), .BUSY(busy[0]), .DONE(done[0]),
        .PASS(pass[0]), .ERR_CNT(err[0]), .FAIL_VEC(fv[0])
`ifdef SC_USE_PG_PIN
        , .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0)
`endif
    );

    scs8hd_a21o_bist #(.SETTLE_CYCLES(2), .LOOPS(3)) u_dut1 (
        .CLK(clk), .RESET_B(rst_n[1]), .START(start[1]), .X_IN(x_in[1]),
        .A1(a1[1]), .A2(a2[1]), .B1(b1[1]), .BUSY(busy[1]), .DONE(done[1]),
        .PASS(pass[1]), .ERR_CNT(err[1]), .FAIL_VEC(fv[1])
`ifdef SC_USE_PG_PIN
        , .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0)
`endif
    );

    scs8hd_a21o_bist #(.SETTLE_CYCLES(0), .LOOPS(4)) u_dut2 (
        .CLK(clk), .RESET_B(rst_n[2]), .START(start[2]), .X_IN(x_in[2]),
        .A1(a1[2]), .A2(a2[2]), .B1(b1[2]), .BUSY(busy[2]), .DONE(done[2]),
        .PASS(pass[2]), .ERR_CNT(err[2]), .FAIL_VEC(fv[2])
`ifdef SC_USE_PG_PIN
        , .vpwr(1'b1), .vgnd(1'b0), .vpb(1'b1), .vnb(1'b0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] stim(input int d);
        return {a1[d], a2[d], b1[d]};
    endfunction

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_stim"}, 32'(stim(d)), 0);
        chk({tag, "_busy"}, 32'(busy[d]), 0);
        chk({tag, "_done"}, 32'(done[d]), 0);
        chk({tag, "_pass"}, 32'(pass[d]), 0);
        chk({tag, "_err"},  32'(err[d]),  0);
        chk({tag, "_fv"},   32'(fv[d]),   0);
    endtask

    // One full run on instance d with fault mask m; START is re-pulsed
    // during cycles ra and rb of the run (negative = never).
    task automatic run_check(input int d, input logic [7:0] m, input int ra, input int rb,
                             input string tag);
        int cyc;
        int n_len;
        int e_err;
        n_len = 8 * loops_of[d] * (s_of[d] + 1);
        e_err = $countones(m) * loops_of[d];
        if (e_err > 15) e_err = 15;
        xmask[d] = m;
        @(posedge clk); #1;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        cyc = 0;
        chk({tag, "_busy0"}, 32'(busy[d]), 1);
        chk({tag, "_err0"},  32'(err[d]),  0);
        chk({tag, "_fv0"},   32'(fv[d]),   0);
        while (done[d] !== 1'b1 && cyc <= n_len) begin
            chk({tag, "_vec"}, 32'(stim(d)), 32'((cyc / (s_of[d] + 1)) % 8));
            start[d] = (cyc == ra || cyc == rb);
            @(posedge clk); #1;
            cyc++;
        end
        start[d] = 1'b0;
        chk({tag, "_len"},  32'(cyc), 32'(n_len));
        chk({tag, "_done"}, 32'(done[d]), 1);
        chk({tag, "_busyF"}, 32'(busy[d]), 0);
        chk({tag, "_pass"}, 32'(pass[d]), 32'(m == 8'h00));
        chk({tag, "_err"},  32'(err[d]),  32'(e_err));
        chk({tag, "_fv"},   32'(fv[d]),   32'(m));
        chk({tag, "_stimF"}, 32'(stim(d)), 0);
        @(posedge clk); #1;
        chk({tag, "_done1"}, 32'(done[d]), 0);
        chk({tag, "_busy1"}, 32'(busy[d]), 0);
        chk({tag, "_hold"},  32'(err[d]),  32'(e_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stuck0;
        int cyc;
        int dn;
        for (int i = 0; i < 8; i++) stuck0[i] = gold(i);
        for (int d = 0; d < 3; d++) xmask[d] = 8'h00;
        rst_n = 3'b000;
        start = 3'b000;
        #12;
        for (int d = 0; d < 3; d++) chk_zero(d, "reset");
        @(posedge clk); #1;
        rst_n = 3'b111;

        run_check(0, 8'h00, -1, -1, "golden");
        run_check(0, stuck0, -1, -1, "stuck0");
        run_check(1, ~stuck0, -1, -1, "stuck1_l3");
        run_check(2, 8'hFF, -1, -1, "invert_s0");
        run_check(0, 8'h00, 5, 23, "repulse");

        // Asynchronous reset during vector 4 of a faulty run.
        xmask[0] = stuck0;
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (13) begin @(posedge clk); #1; end
        chk("midrun_vec4", 32'(stim(0)), 4);
        chk("midrun_errs", 32'(err[0] != 0), 1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk_zero(0, "async_rst");
        start[0] = 1'b1;
        @(posedge clk); #1;
        chk("rst_ignores_start", 32'(busy[0]), 0);
        start[0] = 1'b0;
        rst_n[0] = 1'b1;
        dn = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) dn++;
        end
        chk("no_done_after_abort", 32'(dn), 0);
        chk("wait_fresh_start", 32'(busy[0]), 0);
        run_check(0, 8'h00, -1, -1, "post_rst");

        // START held high: back-to-back runs with a single IDLE cycle between.
        xmask[0] = 8'h00;
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (done[0] !== 1'b1 && cyc <= 24) begin @(posedge clk); #1; cyc++; end
        chk("b2b_len1", 32'(cyc), 24);
        @(posedge clk); #1;
        chk("b2b_gap_busy", 32'(busy[0]), 0);
        chk("b2b_gap_done", 32'(done[0]), 0);
        @(posedge clk); #1;
        chk("b2b_restart", 32'(busy[0]), 1);
        start[0] = 1'b0;
        cyc = 0;
        while (done[0] !== 1'b1 && cyc <= 24) begin @(posedge clk); #1; cyc++; end
        chk("b2b_len2", 32'(cyc), 24);
        chk("b2b_pass", 32'(pass[0]), 1);

        for (int k = 0; k < 6; k++) begin
            logic [7:0] m;
            m = 8'($urandom);
            if (k == 0) m = 8'($urandom_range(1, 3));
            run_check(k % 3, m, -1, -1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
